ps2_key_event_queue: RTL and testbench

Downstream stage of the PS/2 receiver. Takes each completed scan-code byte from the receiver's `PS2KeyboardClk` domain into the system clock domain and folds the `E0`/`F0` prefixes into one key event. Events are queued in a small FIFO that the memory controller drains through a pop interface. The receiver stays a pure byte framer; all prefix handling lives here.

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/key_event_fifo.sv | 76 +++++++
 rtl/ps2_key_event_queue.sv | 106 ++++++++++
 tb/tb_ps2_key_event_queue.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key-event path: decoder states,
// prefix byte values and the layout of a queued key event {brk, ext, code}.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0
  } dec_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int BRK_BIT  = 9;
  localparam int EXT_BIT  = 8;
  localparam int CODE_MSB = 7;
  localparam int EVENT_W  = 10;

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through FIFO with registered count/full/empty and a sticky
// overflow flag raised whenever a push is dropped for lack of space.
module key_event_fifo #(
  parameter int WIDTH  = 10,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_next;
  logic              do_push;
  logic              do_pop;
  logic              drop;

  // A pop frees the slot the same-cycle push needs, so a full FIFO accepts both.
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);
  assign drop    = wr_en && full && !do_pop;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    count_next = count;
    if (do_push && !do_pop)
      count_next = count + 1'b1;
    else if (do_pop && !do_push)
      count_next = count - 1'b1;
  end

  // NOTE: storage is deliberately left out of reset; only pointers and flags are reset,
  // and rd_data is masked while empty so nothing stale is ever presented.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state always uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == FULL_COUNT);
      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ps2_key_event_queue.sv
// Brings PS/2 scan bytes into the system clock domain, folds E0/F0 prefixes
// into {brk, ext, code} key events and queues them for the memory controller.
module ps2_key_event_queue
  import ps2_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         code_in,
  input  logic               code_toggle,
  input  logic               rd_en,
  output logic [EVENT_W-1:0] rd_data,
  output logic               empty,
  output logic               full,
  output logic [ADDR_W:0]    count,
  output logic               overflow,
  input  logic               clr_ovf
);

  logic               t1, t2, t3;
  logic [1:0]         prime_cnt;
  logic               primed;
  logic               byte_strobe;
  logic               is_prefix;
  dec_state_t         state, state_next;
  logic               push;
  logic [EVENT_W-1:0] push_event;

  assign primed = (prime_cnt == 2'd2);

  // While priming, t3 follows t1 so a toggle level present at reset release
  // lines up t2 and t3 and never reads as a transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t1        <= 1'b0;
      t2        <= 1'b0;
      t3        <= 1'b0;
      prime_cnt <= '0;
    end else begin
      t1 <= code_toggle;
      t2 <= t1;
      t3 <= primed ? t2 : t1;
      if (!primed) prime_cnt <= prime_cnt + 2'd1;
    end
  end

  assign byte_strobe = primed && (t2 ^ t3);
  assign is_prefix   = (code_in == PS2_EXT) || (code_in == PS2_BRK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (byte_strobe) begin
      unique case (state)
        ST_IDLE: begin
          if (code_in == PS2_EXT)      state_next = ST_GOT_E0;
          else if (code_in == PS2_BRK) state_next = ST_GOT_F0;
        end
        ST_GOT_E0: begin
          if (code_in == PS2_BRK)      state_next = ST_GOT_E0F0;
          else if (!is_prefix)         state_next = ST_IDLE;
        end
        ST_GOT_F0, ST_GOT_E0F0: begin
          if (!is_prefix)              state_next = ST_IDLE;
        end
        default:                       state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    push       = 1'b0;
    push_event = '0;
    if (byte_strobe && !is_prefix) begin
      push                       = 1'b1;
      push_event[BRK_BIT]        = (state == ST_GOT_F0) || (state == ST_GOT_E0F0);
      push_event[EXT_BIT]        = (state == ST_GOT_E0) || (state == ST_GOT_E0F0);
      push_event[CODE_MSB:0]     = code_in;
    end
  end

  key_event_fifo #(
    .WIDTH  (EVENT_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (push),
    .wr_data  (push_event),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed bench for ps2_key_event_queue: expected key events are queued as
// bytes are sent and compared against rd_data as the FIFO is drained.
module tb_ps2_key_event_queue;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] code_in;
  logic       code_toggle;
  logic       rd_en;
  logic       clr_ovf;
  logic [9:0] rd_data;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overflow;

  int         checks = 0;
  int         errors = 0;
  logic [9:0] exp_q [$];
  logic [9:0] head;

  ps2_key_event_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .code_in     (code_in),
    .code_toggle (code_toggle),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overflow    (overflow),
    .clr_ovf     (clr_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One receiver frame: data held stable well before and after the toggle edge.
  task automatic send_byte(input logic [7:0] b);
    code_in = b;
    tick(3);
    code_toggle = ~code_toggle;
    tick(6);
  endtask

  task automatic pop_check(input string tag);
    check({tag, "_not_empty"}, 16'(empty), 16'h0);
    check({tag, "_sb_pending"}, 16'(exp_q.size() != 0), 16'h1);
    if (exp_q.size() != 0) begin
      head = exp_q.pop_front();
      check(tag, 16'(rd_data), 16'(head));
    end
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    code_in     = 8'h00;
    code_toggle = 1'b0;
    rd_en       = 1'b0;
    clr_ovf     = 1'b0;
    tick(2);
    check("rst_rd_data",  16'(rd_data),  16'h0);
    check("rst_empty",    16'(empty),    16'h1);
    check("rst_full",     16'(full),     16'h0);
    check("rst_count",    16'(count),    16'h0);
    check("rst_overflow", 16'(overflow), 16'h0);
    reset = 1'b0;
    tick(4);

    // Single key with latency: toggle settles before edge N, event visible after N+2.
    exp_q.push_back(10'h01C);
    code_in = 8'h1C;
    tick(3);
    code_toggle = ~code_toggle;
    tick(1);
    check("lat_empty_n",  16'(empty), 16'h1);
    tick(1);
    check("lat_empty_n1", 16'(empty), 16'h1);
    tick(1);
    check("lat_empty_n2", 16'(empty), 16'h0);
    tick(3);
    send_byte(8'hF0);
    exp_q.push_back(10'h21C);
    send_byte(8'h1C);
    check("single_count", 16'(count), 16'h2);
    pop_check("single_make");
    pop_check("single_break");
    check("single_empty", 16'(empty), 16'h1);

    // Extended key: prefixes alone never produce events.
    send_byte(8'hE0);
    check("ext_prefix_count", 16'(count), 16'h0);
    exp_q.push_back(10'h175);
    send_byte(8'h75);
    send_byte(8'hE0);
    send_byte(8'hF0);
    check("ext_prefix2_count", 16'(count), 16'h1);
    exp_q.push_back(10'h375);
    send_byte(8'h75);
    check("ext_count", 16'(count), 16'h2);
    pop_check("ext_make");
    pop_check("ext_break");

    // Overflow: DEPTH+1 plain codes, the last is dropped.
    for (int i = 1; i <= DEPTH + 1; i++) begin
      if (i <= DEPTH) exp_q.push_back(10'(i));
      send_byte(8'(i));
      if (i == DEPTH) begin
        check("ovf_full_at_depth", 16'(full),     16'h1);
        check("ovf_clear_at_depth", 16'(overflow), 16'h0);
      end
    end
    check("ovf_full",  16'(full),     16'h1);
    check("ovf_flag",  16'(overflow), 16'h1);
    check("ovf_count", 16'(count),    16'(DEPTH));
    for (int i = 0; i < DEPTH; i++) pop_check("ovf_drain");
    check("ovf_drained_empty", 16'(empty),    16'h1);
    check("ovf_sticky",        16'(overflow), 16'h1);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    check("ovf_cleared", 16'(overflow), 16'h0);

    // Full boundary: pop lands on the same edge as the push into a full FIFO.
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(10'h011 + 10'(i));
      send_byte(8'h11 + 8'(i));
    end
    check("fb_full", 16'(full), 16'h1);
    code_in = 8'h19;
    tick(3);
    code_toggle = ~code_toggle;
    tick(2);
    head = exp_q.pop_front();
    check("fb_head", 16'(rd_data), 16'(head));
    exp_q.push_back(10'h019);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    check("fb_count",    16'(count),    16'(DEPTH));
    check("fb_full_hold", 16'(full),    16'h1);
    check("fb_no_ovf",   16'(overflow), 16'h0);
    tick(3);
    for (int i = 0; i < DEPTH; i++) pop_check("fb_drain");
    check("fb_empty", 16'(empty), 16'h1);

    // Reset with a pending break prefix discards the prefix.
    send_byte(8'hF0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(3);
    exp_q.push_back(10'h01C);
    send_byte(8'h1C);
    pop_check("rst_prefix_make");

    // Toggle held high through reset release must not create an event.
    reset = 1'b1;
    code_toggle = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(10);
    check("rst_toggle_empty", 16'(empty), 16'h1);
    check("rst_toggle_count", 16'(count), 16'h0);
    exp_q.push_back(10'h02A);
    send_byte(8'h2A);
    pop_check("rst_toggle_after");

    // Empty boundary: pops while empty change nothing.
    rd_en = 1'b1;
    tick(3);
    rd_en = 1'b0;
    check("eb_count", 16'(count), 16'h0);
    check("eb_empty", 16'(empty), 16'h1);
    exp_q.push_back(10'h033);
    send_byte(8'h33);
    check("eb_count_after", 16'(count), 16'h1);
    pop_check("eb_read");

    check("sb_all_consumed", 16'(exp_q.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
